uart_tx: RTL
============

# uart_tx

Serial UART transmitter that drives the line consumed by `uart_rx`. It accepts one parallel byte per valid/ready handshake and shifts out an 8N1 frame: one start bit (0), eight data bits LSB first, and one stop bit (1). Bit timing comes from a baud counter that restarts at each frame start. It sits between the byte-producing logic and the serial pin, and serves as the bench stimulus source for `uart_rx`.

## Interface
- `SYS_CLOCK`, default 1000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bits/s.
- `DIVISION`, derived localparam, `SYS_CLOCK / BAUD_RATE` with integer truncation (104 at defaults): clocks per bit.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-low reset; sampled on the `clk` rising edge while low.
- `tx_data`  input  8  byte to send; sampled only on the accept edge.
- `tx_valid`  input  1  upstream has a byte on `tx_data`.
- `tx_ready`  output  1  registered; high only in IDLE.
- `tx_output`  output  1  registered serial line; idles high.
- `busy`  output  1  registered; high from the cycle after accept until the frame completes.

## Operation
- Accept: an accept edge is a rising edge with `tx_valid && tx_ready`. On it, `tx_data` is latched into an internal 8-bit shift register.
- States: IDLE, START, DATA, STOP (4-state FSM).
- Counters:
  - `baud_cnt` is 16 bits and counts 0..DIVISION-1. It is cleared on accept and on every bit boundary.
  - `bit_idx` is 3 bits and counts 0..7 during DATA.
- IDLE:
  - `tx_output`=1, `busy`=0, `tx_ready`=1.
  - On accept: go to START, `tx_output`<=0, `busy`<=1, `tx_ready`<=0.
- START:
  - When `baud_cnt`==DIVISION-1: go to DATA with `bit_idx`=0 and `tx_output`<=data[0].
- DATA:
  - At each `baud_cnt`==DIVISION-1 with `bit_idx`<7: increment `bit_idx` and output the next bit, LSB first.
  - At `bit_idx`==7: go to STOP with `tx_output`<=1.
- STOP:
  - When `baud_cnt`==DIVISION-1: go to IDLE with `busy`<=0 and `tx_ready`<=1. `tx_output` stays 1.
- While busy:
  - `tx_valid` and `tx_data` are ignored. The latched byte is immune to input changes.
  - There is no queueing.
- Reset (`reset`==0) takes effect at the next edge from any state:
  - state IDLE, `tx_output`=1, `busy`=0, `tx_ready`=1, counters 0.
  - A frame in flight is aborted. There is no partial stop bit.
- Elaboration check: DIVISION must satisfy 2 ≤ DIVISION ≤ 65535. Otherwise error out.

## Timing
- Reset values: `tx_output`=1, `busy`=0, `tx_ready`=1.
- Accept latency: call the accept edge cycle 0. `tx_output` is low for cycles 1..DIVISION.
- Bit k (k=0..7) occupies cycles (k+1)·DIVISION+1 .. (k+2)·DIVISION.
- The stop bit occupies cycles 9·DIVISION+1 .. 10·DIVISION.
- Completion: at cycle 10·DIVISION+1, the FSM is in IDLE with `tx_ready`=1. A new accept is possible on that edge.
- Back-to-back frames (with `tx_valid` held high):
  - The next start bit begins at cycle 10·DIVISION+2.
  - The inter-frame gap is exactly one extra high clock, so the stop bit is DIVISION+1 clocks. This is legal 8N1.
- Every bit is exactly DIVISION clocks. There is no cumulative drift within a frame.

## Structure
- Shared package/include `uart_pkg`:
  - FSM state encoding (IDLE/START/DATA/STOP).
  - `UART_DATA_BITS`=8.
  - `UART_FRAME_BITS`=10.
  - The DIVISION computation macro/function, so `uart_rx` and `uart_tx` agree.
- Optional sub-module `uart_baud_gen`:
  - Parameter DIVISION.
  - Inputs: `clk`, `reset`, `restart`.
  - Output: 1-cycle `tick` at `baud_cnt`==DIVISION-1.
  - The top-level FSM advances on `tick`.

## Test plan
All scenarios use defaults, DIVISION=104, frame = 1040 clocks.
- Reset: hold `reset`=0 for 3 cycles, then release -> `tx_output`=1, `busy`=0, `tx_ready`=1. With `tx_valid`=0 the line stays high for 2000 cycles.
- Single byte 0xA5:
  - Stimulus: pulse `tx_valid` for one cycle.
  - Required line sequence, each level held 104 clocks from cycle 1: 0,1,0,1,0,0,1,0,1,1.
  - `busy` is high for cycles 1..1040. `tx_ready` returns high at cycle 1041.
- Back-to-back: 0x00 then 0xFF with `tx_valid` held high.
  - The second accept occurs at cycle 1041. The second start bit falls at cycle 1042.
  - Frame 2 data bits are all 1.
  - The line is high for 105 clocks between the frames (stop bit plus one gap clock).
- Input stability:
  - Stimulus: accept 0x3C, then toggle `tx_data` every cycle and pulse `tx_valid` during the frame.
  - Required: the serialized bits are 0x3C, and no second frame starts.
- Mid-frame reset:
  - Stimulus: assert `reset`=0 at cycle 400 (inside data bit 2).
  - Required: the next edge gives `tx_output`=1, `busy`=0, `tx_ready`=1.
  - After release, sending 0x81 produces a clean frame: 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and the
// clocks-per-bit computation used by both uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  // Truncating division so transmitter and receiver land on the same bit period.
  function automatic int unsigned uart_division(input int unsigned sys_clock,
                                                input int unsigned baud_rate);
    return sys_clock / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIVISION-1, restarts on request, and
// flags the last clock of each bit period with a one-cycle tick.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIVISION = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST_CNT = 16'(DIVISION - 1);

  logic [15:0] baud_cnt;

  assign tick = (baud_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      baud_cnt <= 16'd0;
    end else if (restart || tick) begin
      baud_cnt <= 16'd0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake and
// shifts it out LSB first between a low start bit and a high stop bit.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | line high, tx_ready high, waiting for tx_valid
//   ST_START | driving the start bit (0) for one bit period
//   ST_DATA  | driving data bit bit_idx, LSB first
//   ST_STOP  | driving the stop bit (1) for one bit period
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLOCK = 1000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_output,
  output logic       busy
);

  localparam int unsigned DIVISION = uart_division(SYS_CLOCK, BAUD_RATE);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  if ((DIVISION < 2) || (DIVISION > 65535)) begin : g_bad_division
    $error("uart_tx: SYS_CLOCK/BAUD_RATE = %0d is outside 2..65535", DIVISION);
  end

  uart_state_e state, state_nx;
  logic [7:0]  shift_q, shift_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic        tx_output_nx;
  logic        busy_nx;
  logic        tx_ready_nx;
  logic        restart;
  logic        tick;
  logic        accept;

  assign accept = tx_valid && tx_ready;

  uart_baud_gen #(
    .DIVISION (DIVISION)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shift_q   <= 8'd0;
      bit_idx   <= 3'd0;
      tx_output <= 1'b1;
      busy      <= 1'b0;
      tx_ready  <= 1'b1;
    end else begin
      state     <= state_nx;
      shift_q   <= shift_nx;
      bit_idx   <= bit_idx_nx;
      tx_output <= tx_output_nx;
      busy      <= busy_nx;
      tx_ready  <= tx_ready_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    shift_nx     = shift_q;
    bit_idx_nx   = bit_idx;
    tx_output_nx = tx_output;
    busy_nx      = busy;
    tx_ready_nx  = tx_ready;
    restart      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        tx_output_nx = 1'b1;
        busy_nx      = 1'b0;
        tx_ready_nx  = 1'b1;
        if (accept) begin
          state_nx     = ST_START;
          shift_nx     = tx_data;
          bit_idx_nx   = 3'd0;
          tx_output_nx = 1'b0;
          busy_nx      = 1'b1;
          tx_ready_nx  = 1'b0;
          restart      = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          state_nx     = ST_DATA;
          bit_idx_nx   = 3'd0;
          tx_output_nx = shift_q[0];
          shift_nx     = shift_q >> 1;
        end
      end

      // The shift register is consumed from bit 0, so the next bit is always shift_q[0].
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            state_nx     = ST_STOP;
            tx_output_nx = 1'b1;
          end else begin
            bit_idx_nx   = bit_idx + 3'd1;
            tx_output_nx = shift_q[0];
            shift_nx     = shift_q >> 1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          state_nx     = ST_IDLE;
          tx_output_nx = 1'b1;
          busy_nx      = 1'b0;
          tx_ready_nx  = 1'b1;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
